shift_add_multiplier: RTL
=========================

Name: shift_add_multiplier

Overview:
- Sequential unsigned 8x8 shift-and-add multiplier producing a 16-bit product.
- Drives the existing eight_bit_full_adder once per iteration: it feeds that adder its operands and consumes the sum and carry.
- Multi-cycle start/done handshake; intended as the multiply stage beside the adder/subtractor datapath.

Parameters:
- WIDTH, 8, operand width. Fixed at 8 because the adder instance is eight_bit_full_adder. Other values are unsupported.
- CNT_W, 4, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset; one clock, reset is asynchronous and active-high
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  multiplicand; latched on accepted start
- B  input  WIDTH  multiplier; latched on accepted start
- busy  output  1  high in RUN
- done  output  1  one-cycle completion pulse
- P  output  2*WIDTH  product register

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, P=0, internal regs=0. Recovery is synchronous on the first edge after rst falls. Reset mid-RUN aborts the operation, and no done pulse is produced.
- States:
  - IDLE: waiting for start.
  - RUN: WIDTH iterations.
  - DONE: single cycle.
- IDLE -> RUN on edge with start=1:
  - mcand<=A, mreg<=B, acc<=0, cnt<=0.
  - start=0 stays IDLE.
- RUN, each edge:
  - Adder inputs: acc and (mreg[0] ? mcand : 0), Cin=0, giving {cout,sum}.
  - Update: {acc,mreg} <= {cout,sum,mreg} >> 1, a 2*WIDTH+1-bit shift right by one.
  - cnt<=cnt+1.
  - When cnt==WIDTH-1 on this edge: next state DONE, and P<={acc,mreg} computed from the post-update values.
- DONE: done=1 for exactly one cycle, busy=0. DONE -> IDLE unconditionally.
- Latency:
  - Start accepted at edge k.
  - busy=1 from after edge k to edge k+WIDTH.
  - done=1 from edge k+WIDTH to edge k+WIDTH+1.
  - P valid at the same time as done.
- P holds the last completed product until the next completion or reset. P is unchanged during RUN.
- start while in RUN or DONE: ignored. No queuing; a new request must be re-asserted in IDLE. Back-to-back operations therefore have a minimum period of WIDTH+2 cycles.
- A and B may change freely after acceptance; only the latched copies are used.
- Arithmetic: unsigned only. The product never overflows 2*WIDTH bits (max 255*255=65025). The adder carry is captured into acc's MSB by the shift, never dropped.
- busy and done are registered, Moore-decoded from state; they are never high together.

Decomposition:
- Shared package/header: state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2; WIDTH and CNT_W defaults.
- One sub-module instance: the existing eight_bit_full_adder (A,B,Cin,Cout,S) as the partial-sum adder.
- Control FSM and shift registers stay in this module; no further hierarchy.

Test Plan:
- Reset then A=3,B=5, start one cycle -> busy for 8 cycles, done pulse at edge k+8, P=15.
- A=255,B=255 -> P=65025 (16'hFE01). Exercises the carry path every iteration.
- A=0,B=200 then A=200,B=0 -> P=0 both times; done still pulses after 8 cycles each.
- Start A=12,B=10; at RUN cycle 3 pulse start with A=7,B=7 -> ignored; P=120, single done pulse.
- Start A=100,B=100; assert rst at RUN cycle 4 -> immediate busy=0, done=0, P=0; no done afterwards. Then A=6,B=7 -> P=42.
- Back-to-back: A=15,B=17 then start again on the first IDLE cycle with A=128,B=2 -> P=255, then P=256; done pulses exactly 10 cycles apart.

Source files
------------

// File: rtl/shift_add_multiplier_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_multiplier_pkg
// Description : Shared definitions for the sequential shift-and-add
//               multiplier. It holds the default operand and counter widths
//               and the control FSM state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package shift_add_multiplier_pkg;

    // The operand width is fixed at 8 because the partial-sum adder is
    // eight_bit_full_adder.
    localparam int c_WIDTH = 8;

    // The iteration counter must be able to hold WIDTH-1 (2^CNT_W > WIDTH).
    localparam int c_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : shift_add_multiplier_pkg
`default_nettype wire

// File: rtl/shift_add_multiplier_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_multiplier_if
// Description : Start/done handshake bundle for the multiplier.
//               master : requester (drives start, A, B; observes result)
//               slave  : multiplier (consumes request, drives result)
// Ports       : start - request, sampled only while the multiplier is idle
//               A, B  - multiplicand / multiplier operands
//               busy  - high while iterating
//               done  - one-cycle completion pulse
//               P     - product register
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_add_multiplier_if
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = c_WIDTH
) ();

    logic                 start;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   P;

    modport master (
        output start,
        output A,
        output B,
        input  busy,
        input  done,
        input  P
    );

    modport slave (
        input  start,
        input  A,
        input  B,
        output busy,
        output done,
        output P
    );

endinterface : shift_add_multiplier_if
`default_nettype wire

// File: rtl/eight_bit_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : eight_bit_full_adder
// Description : 8-bit ripple-carry adder built from single-bit full adders.
// Ports       : A, B - 8-bit addends
//               Cin  - carry in
//               Cout - carry out of bit 7
//               S    - 8-bit sum
// Revision    : 1.0 - initial release
// ============================================================================
module eight_bit_full_adder (
    input  wire logic [7:0] A,
    input  wire logic [7:0] B,
    input  wire logic       Cin,
    output logic            Cout,
    output logic [7:0]      S
);

    logic [8:0] w_carry;

    assign w_carry[0] = Cin;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign S[i]         = A[i] ^ B[i] ^ w_carry[i];
        assign w_carry[i+1] = (A[i] & B[i]) | (w_carry[i] & (A[i] ^ B[i]));
    end

    assign Cout = w_carry[8];

endmodule : eight_bit_full_adder
`default_nettype wire

// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_multiplier
// Description : Sequential unsigned WIDTH x WIDTH shift-and-add multiplier.
//               It performs one add-and-shift per cycle over WIDTH cycles,
//               then pulses done for one cycle with the product in P.
// Ports       : clk - clock, rising edge
//               rst - asynchronous active-high reset
//               bus - handshake (start, A, B in; busy, done, P out)
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int CNT_W = c_CNT_W
) (
    input  wire logic              clk,
    input  wire logic              rst,
    shift_add_multiplier_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    state_t               r_state;
    state_t               w_next_state;

    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mreg;
    logic [WIDTH-1:0]     r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_p;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_load;
    logic                 w_step;
    logic                 w_last;
    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH-1:0]     w_sum;
    logic                 w_cout;
    logic [WIDTH-1:0]     w_acc_next;
    logic [WIDTH-1:0]     w_mreg_next;

    // ------------------------------------------------------------------
    // Partial-sum adder: acc + (multiplier LSB ? multiplicand : 0)
    // ------------------------------------------------------------------
    assign w_addend = r_mreg[0] ? r_mcand : '0;

    eight_bit_full_adder u_adder (
        .A    (r_acc),
        .B    (w_addend),
        .Cin  (1'b0),
        .Cout (w_cout),
        .S    (w_sum)
    );

    // {cout,sum,mreg} >> 1. The carry lands in the acc MSB, so a 255*255
    // partial sum is never truncated. The sum LSB moves into the multiplier
    // register as the consumed multiplier bit drops out the bottom.
    assign w_acc_next  = {w_cout, w_sum[WIDTH-1:1]};
    assign w_mreg_next = {w_sum[0], r_mreg[WIDTH-1:1]};

    // ------------------------------------------------------------------
    // Control FSM: next state and datapath strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next_state = RUN;
                    w_load       = 1'b1;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (r_cnt == c_LAST) begin
                    w_last       = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // busy/done are decoded from the next state and registered, so they
    // follow the state register exactly and come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state == RUN);
            r_done  <= (w_next_state == DONE);
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand <= '0;
            r_mreg  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_p     <= '0;
        end else begin
            if (w_load) begin
                r_mcand <= bus.A;
                r_mreg  <= bus.B;
                r_acc   <= '0;
                r_cnt   <= '0;
            end else if (w_step) begin
                r_acc   <= w_acc_next;
                r_mreg  <= w_mreg_next;
                r_cnt   <= r_cnt + 1'b1;
            end
            // The product is published from the post-update values on the
            // final iteration, so it becomes valid together with done.
            if (w_last) begin
                r_p <= {w_acc_next, w_mreg_next};
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.P    = r_p;

endmodule : shift_add_multiplier
`default_nettype wire
